v_ist_retire: RTL and testbench
===============================

Name: v_ist_retire

Overview:
- Consumer end of the vector instruction status table (IST).
- The sequencer enqueues issued instructions, one per slot in FIFO order. Pipeline stages report stage advancement per slot tag.
- The block retires instructions strictly in program order once the head entry reaches the writes-results stage.
- It sits between the sequencer issue logic and the commit/scoreboard-release logic.

Parameters:
- IST_ENTRY_BITS, 9, entry width: op[5:0] in bits [8:3], stage[2:0] in bits [2:0].
- NO_OF_SLOTS, 8, table depth. Must be a power of 2 and at least 2.
- TAG_BITS, $clog2(NO_OF_SLOTS), slot tag width (3 by default).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- nrst  in  1  synchronous, active-high reset.
- enq_valid  in  1  sequencer presents a new instruction.
- enq_op  in  6  opcode of the new instruction.
- enq_ready  out  1  table can accept; equals !full.
- enq_tag  out  TAG_BITS  slot the next enqueue will occupy (tail pointer).
- upd_valid  in  1  stage-advance report.
- upd_tag  in  TAG_BITS  slot being advanced.
- upd_stage  in  3  new stage for that slot.
- ret_valid  out  1  head entry is ready to retire.
- ret_ready  in  1  commit logic accepts retirement.
- ret_op  out  6  opcode of head entry.
- ret_tag  out  TAG_BITS  slot index of head entry.
- count  out  TAG_BITS+1  number of occupied slots (0..NO_OF_SLOTS).
- upd_err  out  1  registered one-cycle pulse on an illegal update.

Behaviour:
- Stage encoding: 000 issue, 001 read operands, 010 execute, 011 writes results. Values 1xx are illegal.
- Storage: per-slot valid bit, entry register, head pointer, tail pointer, count.
- Reset (nrst=1 at an edge):
  - head=0, tail=0, count=0, all valid bits 0, upd_err=0.
  - Entry contents are don't-care.
  - Reset mid-operation discards all entries; any enq, upd or ret in that cycle is ignored.
- Outputs (combinational from registers):
  - enq_ready = (count != NO_OF_SLOTS).
  - enq_tag = tail.
  - ret_valid = (count != 0) && stage[head] == 011.
  - ret_op = entry[head][8:3].
  - ret_tag = head.
- Enqueue fires when enq_valid && enq_ready:
  - slot[tail] gets {enq_op, 000} and valid=1.
  - tail increments modulo NO_OF_SLOTS, so it wraps from NO_OF_SLOTS-1 to 0.
- Retire fires when ret_valid && ret_ready:
  - valid[head] is cleared.
  - head increments modulo NO_OF_SLOTS.
- count update: +1 on enqueue only, -1 on retire only, unchanged when both or neither fire.
- Full with simultaneous retire: enq_ready is 0 because it is based on registered count. No same-cycle bypass; the enqueue is accepted the following cycle.
- Update is legal only if valid[upd_tag]=1 and upd_stage == stage[upd_tag]+1.
  - Legal update: stage[upd_tag] is written at the edge.
  - Illegal update (invalid slot, skipped stage, backward or repeated stage, or stage 1xx): entry unchanged, upd_err=1 for exactly the next cycle.
  - upd_err is 0 whenever upd_valid=0.
- Update and retire in the same cycle use pre-edge state.
  - An update to the head tag while it retires is necessarily illegal (head stage is already 011) and flags upd_err.
- Update to the slot being enqueued in the same cycle sees valid=0, so it is illegal and flags upd_err.
- Out-of-order completion is allowed: non-head slots may reach 011 first. They wait until they become head.
- Latency: a legal update to the head writing 011 at edge N gives ret_valid=1 from edge N onward. Retire takes effect at the accepting edge.
- ret_valid may stay asserted without ret_ready; outputs stay stable until accepted.
- Empty: ret_valid=0 regardless of stale entry contents.

Test Plan:
- Reset then idle: count=0, enq_ready=1, enq_tag=0, ret_valid=0, upd_err=0. Assert nrst mid-run with count=5 → all of these return to the same values the next cycle.
- Enqueue ops 0x01..0x08 back-to-back → count=8, enq_ready=0. A 9th enq_valid with op 0x09 is dropped; count stays 8.
- Tag 0 advanced 001, 010, 011 on consecutive cycles → ret_valid=1 with ret_op=0x01, ret_tag=0 after the third edge. With ret_ready=1, the next cycle gives count-1 and head=1.
- Tag 2 reaches 011 while tag 0 is at 010 → ret_valid=0. Advance tag 0 and tag 1 to 011 → three consecutive retires with ret_tag 0, 1, 2 in order.
- Illegal updates: tag 3 jumping 000→010, an update to an empty slot, and upd_stage=100 → each gives upd_err high for exactly one cycle and the entry is unchanged.
- Full table with head at 011, ret_ready=1 and enq_valid=1 in the same cycle → retire only, count 8→7. Next cycle the enqueue lands at the wrapped tail with enq_tag=0 after 8 prior enqueues, and count returns to 8.

Source files
------------

// File: rtl/v_ist_retire.sv
// v_ist_retire: consumer end of the vector instruction status table.
// Holds issued instructions in FIFO order and retires them in program order.
module v_ist_retire #(
    parameter int IST_ENTRY_BITS = 9,
    parameter int NO_OF_SLOTS    = 8,
    parameter int TAG_BITS       = $clog2(NO_OF_SLOTS)
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                enq_valid,
    input  logic [5:0]          enq_op,
    output logic                enq_ready,
    output logic [TAG_BITS-1:0] enq_tag,
    input  logic                upd_valid,
    input  logic [TAG_BITS-1:0] upd_tag,
    input  logic [2:0]          upd_stage,
    output logic                ret_valid,
    input  logic                ret_ready,
    output logic [5:0]          ret_op,
    output logic [TAG_BITS-1:0] ret_tag,
    output logic [TAG_BITS:0]   count,
    output logic                upd_err
);

    localparam logic [2:0]          ST_ISSUE = 3'b000;
    localparam logic [2:0]          ST_WR    = 3'b011;
    localparam logic [TAG_BITS:0]   FULL_CNT = (TAG_BITS+1)'(NO_OF_SLOTS);
    localparam logic [TAG_BITS:0]   ONE_C    = (TAG_BITS+1)'(1);
    localparam logic [TAG_BITS-1:0] ONE_T    = TAG_BITS'(1);

    logic [NO_OF_SLOTS-1:0]    valid_q, valid_d;
    logic [IST_ENTRY_BITS-1:0] entry_q [NO_OF_SLOTS];
    logic [IST_ENTRY_BITS-1:0] entry_d [NO_OF_SLOTS];
    logic [TAG_BITS-1:0]       head_q, head_d;
    logic [TAG_BITS-1:0]       tail_q, tail_d;
    logic [TAG_BITS:0]         count_q, count_d;
    logic                      upd_err_q, upd_err_d;

    logic       enq_fire;
    logic       ret_fire;
    logic       upd_legal;
    logic [2:0] head_stage;
    logic [2:0] upd_cur_stage;

    // Status outputs come straight from registered state
    always_comb begin
        head_stage    = entry_q[head_q][2:0];
        upd_cur_stage = entry_q[upd_tag][2:0];
        enq_ready     = (count_q != FULL_CNT);
        enq_tag       = tail_q;
        ret_valid     = (count_q != '0) && (head_stage == ST_WR);
        ret_op        = entry_q[head_q][IST_ENTRY_BITS-1:3];
        ret_tag       = head_q;
        count         = count_q;
        upd_err       = upd_err_q;
    end

    // Handshake fires and update legality, all from pre-edge state
    always_comb begin
        enq_fire  = enq_valid && enq_ready;
        ret_fire  = ret_valid && ret_ready;
        // Stage 011 + 1 yields 100, so the msb test also rejects overruns
        upd_legal = valid_q[upd_tag]
                 && !upd_stage[2]
                 && (upd_stage == upd_cur_stage + 3'b001);
    end

    // Next-state for entries: enqueue fills the tail, legal update sets stage
    always_comb begin
        for (int i = 0; i < NO_OF_SLOTS; i++) begin
            entry_d[i] = entry_q[i];
        end
        if (upd_valid && upd_legal) begin
            entry_d[upd_tag] = {entry_q[upd_tag][IST_ENTRY_BITS-1:3], upd_stage};
        end
        // Tail slot is never valid when enqueue fires, so no clash with update
        if (enq_fire) begin
            entry_d[tail_q] = {enq_op, ST_ISSUE};
        end
    end

    // Next-state for valid bits, pointers, occupancy and error pulse
    always_comb begin
        valid_d   = valid_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        upd_err_d = upd_valid && !upd_legal;
        if (ret_fire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + ONE_T;
        end
        if (enq_fire) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + ONE_T;
        end
        unique case ({enq_fire, ret_fire})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (nrst) begin
            valid_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            upd_err_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            upd_err_q <= upd_err_d;
        end
    end

    // Entry payload needs no reset; valid bits gate every use of it
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

endmodule

// File: tb/tb_v_ist_retire.sv
// tb_v_ist_retire: directed plus random stimulus for v_ist_retire,
// checked against a queue-based model of the in-order status table.
module tb_v_ist_retire;

    logic       clk = 1'b0;
    logic       nrst;
    logic       enq_valid;
    logic [5:0] enq_op;
    logic       enq_ready;
    logic [2:0] enq_tag;
    logic       upd_valid;
    logic [2:0] upd_tag;
    logic [2:0] upd_stage;
    logic       ret_valid;
    logic       ret_ready;
    logic [5:0] ret_op;
    logic [2:0] ret_tag;
    logic [3:0] count;
    logic       upd_err;

    v_ist_retire dut (
        .clk       (clk),
        .nrst      (nrst),
        .enq_valid (enq_valid),
        .enq_op    (enq_op),
        .enq_ready (enq_ready),
        .enq_tag   (enq_tag),
        .upd_valid (upd_valid),
        .upd_tag   (upd_tag),
        .upd_stage (upd_stage),
        .ret_valid (ret_valid),
        .ret_ready (ret_ready),
        .ret_op    (ret_op),
        .ret_tag   (ret_tag),
        .count     (count),
        .upd_err   (upd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tag;
        int op;
        int stage;
    } ent_t;

    ent_t mq[$];
    int   m_head;
    int   m_tail;
    bit   m_err;
    int   n_chk;
    int   n_fail;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        bit rv;
        rv = (mq.size() != 0) && (mq[0].stage == 3);
        chk("count", int'(count), mq.size());
        chk("enq_ready", int'(enq_ready), int'(mq.size() != 8));
        chk("enq_tag", int'(enq_tag), m_tail);
        chk("ret_valid", int'(ret_valid), int'(rv));
        chk("ret_tag", int'(ret_tag), m_head);
        chk("upd_err", int'(upd_err), int'(m_err));
        if (mq.size() != 0) chk("ret_op", int'(ret_op), mq[0].op);
    endtask

    task automatic step(input bit rs, input bit ev, input int op,
                        input bit uv, input int ut, input int us,
                        input bit rr);
        bit legal;
        bit rv;
        bit full;
        int idx;
        ent_t e;
        nrst      = rs;
        enq_valid = ev;
        enq_op    = 6'(op);
        upd_valid = uv;
        upd_tag   = 3'(ut);
        upd_stage = 3'(us);
        ret_ready = rr;
        legal = 1'b0;
        idx   = -1;
        full  = (mq.size() == 8);
        rv    = (mq.size() != 0) && (mq[0].stage == 3);
        if (uv) begin
            foreach (mq[i]) begin
                if (mq[i].tag == ut && us == mq[i].stage + 1 && us <= 3) begin
                    legal = 1'b1;
                    idx   = i;
                end
            end
        end
        @(posedge clk);
        if (rs) begin
            mq.delete();
            m_head = 0;
            m_tail = 0;
            m_err  = 1'b0;
        end else begin
            if (legal) mq[idx].stage = us;
            if (rv && rr) begin
                void'(mq.pop_front());
                m_head = (m_head + 1) % 8;
            end
            if (ev && !full) begin
                e.tag   = m_tail;
                e.op    = op & 63;
                e.stage = 0;
                mq.push_back(e);
                m_tail = (m_tail + 1) % 8;
            end
            m_err = uv && !legal;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic enq(input int op);
        step(0, 1, op, 0, 0, 0, 0);
    endtask

    task automatic upd(input int t, input int s);
        step(0, 0, 0, 1, t, s, 0);
    endtask

    task automatic rst();
        step(1, 1, $urandom_range(63), 1, $urandom_range(7),
             $urandom_range(7), 1);
    endtask

    initial begin
        int ut;
        int us;
        int k;
        n_chk = 0;
        n_fail = 0;
        m_head = 0;
        m_tail = 0;
        m_err = 1'b0;
        nrst = 1'b1;
        enq_valid = 1'b0;
        enq_op = '0;
        upd_valid = 1'b0;
        upd_tag = '0;
        upd_stage = '0;
        ret_ready = 1'b0;
        @(negedge clk);

        rst();
        idle();

        for (int i = 1; i <= 8; i++) enq(i);
        enq(9);

        upd(0, 1);
        upd(0, 2);
        upd(0, 3);
        idle();
        step(0, 1, 10, 0, 0, 0, 1);
        enq(10);

        upd(1, 1);
        upd(1, 2);
        upd(2, 1);
        upd(2, 2);
        upd(2, 3);
        idle();

        upd(3, 2);
        idle();
        upd(4, 4);
        idle();
        upd(3, 0);
        upd(2, 3);

        upd(1, 3);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 2, 4, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        idle();

        upd(3, 1);
        upd(3, 2);
        upd(3, 3);
        step(0, 0, 0, 0, 0, 0, 1);
        upd(3, 1);
        step(0, 1, 33, 1, 4, 1, 0);
        step(0, 1, 34, 1, 5, 1, 0);

        rst();
        for (int i = 0; i < 5; i++) enq(20 + i);
        upd(7, 1);
        rst();
        idle();

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(99) < 70 && mq.size() != 0) begin
                k  = $urandom_range(mq.size() - 1);
                ut = mq[k].tag;
                us = mq[k].stage + 1;
            end else begin
                ut = $urandom_range(7);
                us = $urandom_range(7);
            end
            step($urandom_range(299) == 0,
                 $urandom_range(99) < 55,
                 $urandom_range(63),
                 $urandom_range(99) < 80, ut, us,
                 $urandom_range(99) < 50);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
